// File: rtl/demux1_4_if.sv
// Stream bus for the 1-to-4 demultiplexer: one input beat, four buffered outputs.
// Counter signals exist only when DEMUX_CNT_EN is defined.
interface demux1_4_if #(
    parameter int WIDTH = 2,
    parameter int CNT_W = 8
);
    logic [WIDTH-1:0] din;
    logic [1:0]       sel;
    logic             valid_in;
    logic             ready_in;
    logic [WIDTH-1:0] d0, d1, d2, d3;
    logic             v0, v1, v2, v3;
    logic             r0, r1, r2, r3;
`ifdef DEMUX_CNT_EN
    logic [CNT_W-1:0] cnt0, cnt1, cnt2, cnt3;

    modport master (
        output din, sel, valid_in, r0, r1, r2, r3,
        input  ready_in, d0, d1, d2, d3, v0, v1, v2, v3,
        input  cnt0, cnt1, cnt2, cnt3
    );

    modport slave (
        input  din, sel, valid_in, r0, r1, r2, r3,
        output ready_in, d0, d1, d2, d3, v0, v1, v2, v3,
        output cnt0, cnt1, cnt2, cnt3
    );
`else
    modport master (
        output din, sel, valid_in, r0, r1, r2, r3,
        input  ready_in, d0, d1, d2, d3, v0, v1, v2, v3
    );

    modport slave (
        input  din, sel, valid_in, r0, r1, r2, r3,
        output ready_in, d0, d1, d2, d3, v0, v1, v2, v3
    );
`endif
endinterface

// File: rtl/demux1_4.sv
// Registered 1-to-4 stream demultiplexer with a single-entry buffer per channel.
// Optional per-channel delivery counters are enabled by defining DEMUX_CNT_EN.
module demux1_4 #(
    parameter int WIDTH = 2,
    parameter int CNT_W = 8
) (
    input logic        clk,
    input logic        rst_n,
    demux1_4_if.slave  bus
);
    // Mirror of the upstream 4:1 mux encoding: sel 00 -> d3 ... sel 11 -> d0.
    function automatic logic [1:0] map_sel(input logic [1:0] s);
        return ~s;
    endfunction

    logic [1:0]       tgt;
    logic [3:0]       rdy;
    logic [3:0]       acc_oh;
    logic [3:0]       drain;
    logic             accept;
    logic [3:0]       vld_p0;
    logic [WIDTH-1:0] data_p0 [4];

    assign tgt    = map_sel(bus.sel);
    assign rdy    = {bus.r3, bus.r2, bus.r1, bus.r0};
    assign drain  = vld_p0 & rdy;

    assign bus.ready_in = ~vld_p0[tgt] | rdy[tgt];
    assign accept       = bus.valid_in & bus.ready_in;
    assign acc_oh       = accept ? (4'b0001 << tgt) : 4'b0000;

    // Stage p0: channel buffers; an accept wins over a same-cycle drain.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_p0 <= '0;
            for (int k = 0; k < 4; k++) begin
                data_p0[k] <= '0;
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (acc_oh[k]) begin
                    data_p0[k] <= bus.din;
                    vld_p0[k]  <= 1'b1;
                end else if (drain[k]) begin
                    vld_p0[k]  <= 1'b0;
                end
            end
        end
    end

    assign bus.d0 = data_p0[0];
    assign bus.d1 = data_p0[1];
    assign bus.d2 = data_p0[2];
    assign bus.d3 = data_p0[3];
    assign bus.v0 = vld_p0[0];
    assign bus.v1 = vld_p0[1];
    assign bus.v2 = vld_p0[2];
    assign bus.v3 = vld_p0[3];

`ifdef DEMUX_CNT_EN
    logic [CNT_W-1:0] cnt_p0 [4];

    // Delivered-beat counters wrap naturally at 2^CNT_W.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < 4; k++) begin
                cnt_p0[k] <= '0;
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (drain[k]) begin
                    cnt_p0[k] <= cnt_p0[k] + 1'b1;
                end
            end
        end
    end

    assign bus.cnt0 = cnt_p0[0];
    assign bus.cnt1 = cnt_p0[1];
    assign bus.cnt2 = cnt_p0[2];
    assign bus.cnt3 = cnt_p0[3];
`endif
endmodule

// File: tb/tb_demux1_4.sv
// Directed bench for demux1_4: routing, backpressure, independence, reset, streaming.
module tb_demux1_4;
    logic clk = 1'b0;
    logic rst_n;
    int   vectors = 0;
    int   errs    = 0;

    demux1_4_if #(.WIDTH(2), .CNT_W(8)) bus ();

    demux1_4 #(.WIDTH(2), .CNT_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [1:0] s, input logic [1:0] d);
        bus.valid_in = v;
        bus.sel      = s;
        bus.din      = d;
        #1;
    endtask

    task automatic set_r(input logic [3:0] r);
        {bus.r3, bus.r2, bus.r1, bus.r0} = r;
    endtask

    function automatic logic [3:0] vv();
        return {bus.v3, bus.v2, bus.v1, bus.v0};
    endfunction

    initial begin
        rst_n = 1'b0;
        set_r(4'b1111);
        drive(1'b0, 2'b00, 2'b00);
        tick();
        tick();
        chk("reset_v", vv(), 4'b0000);
        chk("reset_d", {bus.d3, bus.d2, bus.d1, bus.d0}, 8'h00);
        chk("reset_ready", bus.ready_in, 1'b1);
`ifdef DEMUX_CNT_EN
        chk("reset_cnt", {bus.cnt3, bus.cnt2, bus.cnt1, bus.cnt0}, 32'h0);
`endif
        rst_n = 1'b1;

        // Routing
        drive(1'b1, 2'b00, 2'b01);
        chk("route_ready", bus.ready_in, 1'b1);
        tick();
        chk("route_v_a", vv(), 4'b1000);
        chk("route_d3", bus.d3, 2'b01);
        drive(1'b1, 2'b01, 2'b10);
        tick();
        chk("route_v_b", vv(), 4'b0100);
        chk("route_d2", bus.d2, 2'b10);
        drive(1'b1, 2'b10, 2'b11);
        tick();
        chk("route_v_c", vv(), 4'b0010);
        chk("route_d1", bus.d1, 2'b11);
        drive(1'b1, 2'b11, 2'b00);
        tick();
        chk("route_v_d", vv(), 4'b0001);
        chk("route_d0", bus.d0, 2'b00);
        drive(1'b0, 2'b00, 2'b11);
        tick();
        chk("route_v_e", vv(), 4'b0000);
        chk("route_d3_kept", bus.d3, 2'b01);

        // Backpressure on channel 3
        set_r(4'b0111);
        drive(1'b1, 2'b00, 2'b10);
        chk("bp_ready_a", bus.ready_in, 1'b1);
        tick();
        chk("bp_v_a", vv(), 4'b1000);
        chk("bp_d3_a", bus.d3, 2'b10);
        drive(1'b1, 2'b00, 2'b01);
        chk("bp_ready_b", bus.ready_in, 1'b0);
        tick();
        chk("bp_v_hold", vv(), 4'b1000);
        chk("bp_d3_hold", bus.d3, 2'b10);
        set_r(4'b1111);
        #1;
        chk("bp_ready_c", bus.ready_in, 1'b1);
        tick();
        chk("bp_v_swap", vv(), 4'b1000);
        chk("bp_d3_swap", bus.d3, 2'b01);
        drive(1'b0, 2'b00, 2'b00);
        tick();
        chk("bp_v_done", vv(), 4'b0000);

        // Independence: channel 2 stalled, channel 0 flows
        set_r(4'b1011);
        drive(1'b1, 2'b01, 2'b10);
        tick();
        chk("ind_v_a", vv(), 4'b0100);
        drive(1'b1, 2'b11, 2'b11);
        chk("ind_ready", bus.ready_in, 1'b1);
        tick();
        chk("ind_v_b", vv(), 4'b0101);
        chk("ind_d0", bus.d0, 2'b11);
        chk("ind_d2", bus.d2, 2'b10);
        drive(1'b0, 2'b00, 2'b00);
        tick();
        chk("ind_v_c", vv(), 4'b0100);
        chk("ind_d2_hold", bus.d2, 2'b10);

        // Reset mid-operation with every channel full
        set_r(4'b0000);
        drive(1'b1, 2'b00, 2'b01);
        tick();
        drive(1'b1, 2'b10, 2'b10);
        tick();
        drive(1'b1, 2'b11, 2'b01);
        tick();
        chk("fill_v", vv(), 4'b1111);
        chk("fill_d", {bus.d3, bus.d2, bus.d1, bus.d0}, 8'b01_10_10_01);
        drive(1'b1, 2'b01, 2'b11);
        chk("fill_ready", bus.ready_in, 1'b0);
        drive(1'b0, 2'b00, 2'b00);
        rst_n = 1'b0;
        tick();
        chk("mrst_v", vv(), 4'b0000);
        chk("mrst_d", {bus.d3, bus.d2, bus.d1, bus.d0}, 8'h00);
        chk("mrst_ready", bus.ready_in, 1'b1);
        rst_n = 1'b1;

        // Streaming on channel 1
        set_r(4'b1111);
        for (int i = 0; i < 300; i++) begin
            logic [1:0] b;
            b = 2'(i * 3 + 1);
            drive(1'b1, 2'b10, b);
            chk("stream_ready", bus.ready_in, 1'b1);
            tick();
            chk("stream_v", vv(), 4'b0010);
            chk("stream_d1", bus.d1, b);
        end
        drive(1'b0, 2'b00, 2'b00);
        tick();
        chk("stream_v_end", vv(), 4'b0000);
`ifdef DEMUX_CNT_EN
        chk("cnt1", bus.cnt1, 8'd44);
        chk("cnt_others", {bus.cnt3, bus.cnt2, bus.cnt0}, 24'h0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule

// File: doc/demux1_4.md
# demux1_4

Registered 1-to-4 stream demultiplexer: the distribution side of the 4:1 select path. It accepts one 2-bit beat per cycle on a valid/ready input and routes it by `sel` into one of four independent single-entry output buffers, each with its own valid/ready handshake. It sits upstream of four consumers that were previously fed by a shared 4:1 mux. Its select encoding is the mirror of that mux, so a beat sent with a given `sel` comes back through the mux with the same `sel`.

## Interface
Parameters:
- `WIDTH`, default 2, data width of every beat.
- `CNT_W`, default 8, width of the per-channel delivery counters. Only used when `DEMUX_CNT_EN` is defined.

Ports:
- `clk` input 1: single clock; all logic is on its rising edge.
- `rst_n` input 1: synchronous, active-low reset, sampled on the rising edge of `clk`.
- `din` input WIDTH: input beat data.
- `sel` input 2: destination select, qualified by `valid_in`.
- `valid_in` input 1: an input beat is present.
- `ready_in` output 1: the block can accept the beat this cycle (combinational).
- `d0`,`d1`,`d2`,`d3` output WIDTH each: registered channel data.
- `v0`..`v3` output 1 each: channel data is valid.
- `r0`..`r3` input 1 each: the consumer accepts this cycle.
- `cnt0`..`cnt3` output CNT_W each: delivered-beat counters. Present only with `DEMUX_CNT_EN`.

## Operation
- Select map, fixed: `sel`=2'b00 goes to d3, 2'b01 to d2, 2'b10 to d1, 2'b11 to d0.
- Each channel k is a one-entry buffer with two states:
  - EMPTY: `vk`=0.
  - FULL: `vk`=1, `dk` holds the beat.
- Define the target channel t = map(`sel`).
- `ready_in` = !`vt` || `rt`. The target buffer is either empty or is being drained this cycle.
- `ready_in` depends only on `sel`, `vt` and `rt`. It does not depend on `valid_in`.
- Accept = `valid_in` && `ready_in`. On accept, `dt` <= `din` and `vt` <= 1.
- Drain on channel k = `vk` && `rk`. On drain without a new accept into k, `vk` <= 0.
- Drain and accept on the same channel in the same cycle: the buffer stays FULL and `dk` takes the new beat. This gives one beat per cycle per channel.
- Non-target channels drain independently in the same cycle as an accept elsewhere.
- While `vk`=1 and `rk`=0, `dk` and `vk` hold stable. No overwrite or drop is allowed.
- When `valid_in`=0, `din` and `sel` are don't-care and no buffer changes except by drain.
- `dk` keeps its last value after drain. Consumers must ignore `dk` while `vk`=0.

## Timing
- Reset (`rst_n`=0 at an edge) sets `v0`..`v3`=0, `d0`..`d3`=0, and `cnt0`..`cnt3`=0.
- During reset, `ready_in` follows its formula from the reset-state `vk`, so it is 1 from the cycle after the reset edge.
- Reset in mid-operation discards all buffered beats, with no delivery.
- Latency: a beat accepted at edge N is visible on `dk`/`vk` right after edge N, and can be consumed at edge N+1.
- The input-to-output path is registered. The only combinational path is `sel`/`rk`/`vk` to `ready_in`.

## Configuration
- `DEMUX_CNT_EN`:
  - Defined: `cnt0`..`cnt3` exist. `cntk` increments by 1 on each drain of channel k. It wraps from 2^CNT_W-1 to 0 and is cleared by reset.
  - Undefined: the counter ports and logic are absent. All other behaviour is identical.

## Test plan
- Routing: after reset, `r0`..`r3`=1; send `din`=2'b01,2'b10,2'b11,2'b00 with `sel`=00,01,10,11 on consecutive cycles -> 2'b01 appears on d3, 2'b10 on d2, 2'b11 on d1, 2'b00 on d0. Each shows `vk`=1 for exactly one cycle, one cycle after its accept.
- Backpressure: `r3`=0; send `sel`=00 `din`=2'b10, then `sel`=00 `din`=2'b01 -> second cycle `ready_in`=0, `d3` holds 2'b10. Raise `r3` -> 2'b01 is accepted in the same cycle 2'b10 drains, and `v3` stays 1.
- Independence: `r2`=0 with d2 FULL; send `sel`=11 `din`=2'b11 -> `ready_in`=1, `d0`=2'b11 next cycle, d2 unchanged.
- Reset mid-operation: fill all four channels with `rk`=0, then assert `rst_n`=0 for one edge -> all `vk`=0, `dk`=0, `ready_in`=1; no beat is delivered.
- Streaming: `sel`=10 held, `r1`=1, 300 beats back to back -> `ready_in` stays 1, d1 shows each beat one cycle late. With `DEMUX_CNT_EN`, `cnt1` reads 300 mod 256 = 44 and the other counters read 0.
